sram_rw_arbiter: RTL and testbench

Controller that fronts one 512 x 76-bit single-port SRAM macro (4 write lanes of 19 bits, 1-cycle read latency). It zero-initialises the array after reset, then shares the single RW port between one write requester and one read requester with write priority and a starvation guard for reads. It sits between pipeline logic and the SRAM wrapper and is the only driver of the macro's port.

---
 rtl/sram_rw_arbiter_pkg.sv | 14 +
 rtl/sram_rw_grant.sv | 40 ++++
 rtl/sram_rw_arbiter.sv | 115 +++++++++++
 tb/tb_sram_rw_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_rw_arbiter_pkg.sv
// Shared types and default geometry for the SRAM read/write arbiter.
// ST_INIT zero-fills the macro after reset. ST_RUN arbitrates the single
// RW port between the write requester and the read requester.
package sram_rw_arbiter_pkg;
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W       = 9;
    localparam int DEF_DATA_W       = 76;
    localparam int DEF_LANES        = 4;
    localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/sram_rw_grant.sv
// Arbitration decision for the shared SRAM port, plus the read-starvation counter.
//   clock, reset_n       : clock and asynchronous active-low reset
//   run                  : arbitration enabled (init sweep finished)
//   wr_valid, rd_valid   : request valids
//   wr_grant, rd_grant   : one-hot grants for the current cycle (combinational)
module sram_rw_grant
    import sram_rw_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic wr_valid,
    input  logic rd_valid,
    output logic wr_grant,
    output logic rd_grant
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;

    assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Writes win ties until a waiting read has watched STARVE_LIMIT writes go by.
    assign wr_grant = run & wr_valid & ~(rd_valid & starve_hit);
    assign rd_grant = run & rd_valid & (~wr_valid | starve_hit);

    // The counter only measures an uninterrupted wait. It clears whenever the
    // read is absent or served. It stays 0 through init because no grants occur.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (!rd_valid || rd_grant)
            starve_cnt <= '0;
        else if (wr_grant && !starve_hit)
            starve_cnt <= starve_cnt + CNT_W'(1);
    end
endmodule

// File: rtl/sram_rw_arbiter.sv
// Sole driver of a single-port SRAM macro. After reset it zero-fills the
// array, one word per cycle. It then grants one write or one read per cycle.
// Writes have priority, and a starvation guard protects reads.
//   clock, reset_n                      : clock, asynchronous active-low reset
//   init_done                           : high once the zero-fill sweep completed
//   wr_valid/wr_ready, wr_addr/mask/data: write request channel
//   rd_valid/rd_ready, rd_addr          : read request channel
//   resp_valid, resp_data               : read response, one cycle after grant
//   sram_en/wmode/addr/wmask/wdata      : macro port (wmode 1 = write)
//   sram_rdata                          : macro read data
module sram_rw_arbiter
    import sram_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int LANES        = DEF_LANES,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              init_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LANES-1:0]  wr_mask,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [LANES-1:0]  sram_wmask,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    arb_state_e        state, state_nxt;
    logic [ADDR_W-1:0] init_ptr;
    logic              run;
    logic              wr_grant, rd_grant;
    logic              vld_pipe;

    assign run       = (state == ST_RUN);
    assign init_done = run;

    sram_rw_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (run),
        .wr_valid (wr_valid),
        .rd_valid (rd_valid),
        .wr_grant (wr_grant),
        .rd_grant (rd_grant)
    );

    // State register and init sweep pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)
                init_ptr <= init_ptr + ADDR_W'(1);
        end
    end

    // Next state: leave INIT on the cycle that writes the last address
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_ptr == {ADDR_W{1'b1}})
            state_nxt = ST_RUN;
    end

    // Port mux. During INIT the enable follows reset_n, so the macro sees no
    // access while reset is held. The first fill write lands on the first
    // edge after release.
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        if (state == ST_INIT) begin
            sram_en    = reset_n;
            sram_wmode = 1'b1;
            sram_wmask = '1;
            sram_addr  = init_ptr;
        end else if (wr_grant) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wr_addr;
            sram_wmask = wr_mask;
            sram_wdata = wr_data;
        end else if (rd_grant) begin
            sram_en   = 1'b1;
            sram_addr = rd_addr;
        end
    end

    assign wr_ready = wr_grant;
    assign rd_ready = rd_grant;

    // Response valid tracks the macro's one-cycle read latency. An async
    // reset drops any response that is still in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_pipe <= 1'b0;
        else          vld_pipe <= rd_grant;
    end

    assign resp_valid = vld_pipe;
    assign resp_data  = sram_rdata;
endmodule

// File: tb/tb_sram_rw_arbiter.sv
module tb_sram_rw_arbiter;
    localparam int AW = 9;
    localparam int DW = 76;
    localparam int LN = 4;
    localparam int LW = DW / LN;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          init_done;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [LN-1:0] wr_mask;
    logic [DW-1:0] wr_data;
    logic          rd_valid, rd_ready;
    logic [AW-1:0] rd_addr;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic          sram_en, sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [LN-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int total = 0;
    int bad   = 0;
    logic watch = 1'b0;
    logic saw_resp = 1'b0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    sram_rw_arbiter dut (
        .clock(clock), .reset_n(reset_n), .init_done(init_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clock = ~clock;

    // Behavioural macro: lane-masked write, 1-cycle read, rdata held between reads
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int l = 0; l < LN; l++)
                    if (sram_wmask[l]) mem[sram_addr][l*LW +: LW] <= sram_wdata[l*LW +: LW];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    always @(posedge resp_valid) if (watch) saw_resp = 1'b1;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view of the port during an init sweep cycle
    function automatic logic [95:0] init_view();
        return 96'({sram_en, sram_wmode, sram_wmask, sram_wdata, sram_addr,
                    wr_ready, rd_ready, init_done});
    endfunction

    function automatic logic [95:0] init_exp(input int c);
        logic [AW-1:0] a;
        a = AW'(c);
        return 96'({1'b1, 1'b1, 4'hF, 76'h0, a, 1'b0, 1'b0, 1'b0});
    endfunction

    initial begin
        logic [DW-1:0] lanes02;
        lanes02 = {19'h0, 19'h7FFFF, 19'h0, 19'h7FFFF};
        for (int i = 0; i < (1<<AW); i++) mem[i] = {4{19'h2AAAA}} ^ DW'(i);
        sram_rdata = '1;
        reset_n = 1'b0;
        wr_valid = 0; wr_addr = '0; wr_mask = '0; wr_data = '0;
        rd_valid = 0; rd_addr = '0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("rst_sram_en",    96'(sram_en), 96'(0));
        chk("rst_init_done",  96'(init_done), 96'(0));
        chk("rst_resp_valid", 96'(resp_valid), 96'(0));
        chk("rst_readies",    96'({wr_ready, rd_ready}), 96'(0));

        // Init sweep: addresses 0..511, all-ones mask, zero data
        @(negedge clock); reset_n = 1'b1; #1;
        for (int c = 0; c < 512; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            chk("init_sweep", init_view(), init_exp(c));
        end

        // Read 300 right after init: returns zero
        @(negedge clock); rd_valid = 1; rd_addr = 9'd300; #1;
        chk("init_done_rise", 96'(init_done), 96'(1));
        chk("rd300_grant", 96'({rd_ready, wr_ready, sram_en, sram_wmode, sram_addr}),
            96'({1'b1, 1'b0, 1'b1, 1'b0, 9'd300}));
        @(negedge clock); rd_valid = 0; #1;
        chk("rd300_resp", 96'({resp_valid, resp_data}), 96'({1'b1, 76'h0}));
        @(negedge clock); #1;
        chk("idle_en", 96'({sram_en, resp_valid, sram_addr, sram_wdata}), 96'(0));

        // Masked write of all ones, lanes 0 and 2
        wr_valid = 1; wr_addr = 9'd5; wr_mask = 4'b0101; wr_data = '1; #1;
        chk("mwr_grant", 96'({wr_ready, sram_wmode, sram_wmask, sram_addr}),
            96'({1'b1, 1'b1, 4'b0101, 9'd5}));
        @(negedge clock); wr_valid = 0; rd_valid = 1; rd_addr = 9'd5; #1;
        chk("mwr_rd_grant", 96'(rd_ready), 96'(1));
        @(negedge clock); rd_valid = 0; #1;
        chk("mwr_resp", 96'({resp_valid, resp_data}), 96'({1'b1, lanes02}));

        // Zero mask still granted, leaves data untouched
        @(negedge clock); wr_valid = 1; wr_mask = 4'b0000; wr_data = '0; #1;
        chk("mask0_grant", 96'({wr_ready, sram_en}), 96'(2'b11));
        @(negedge clock); wr_valid = 0; rd_valid = 1; #1;
        @(negedge clock); rd_valid = 0; #1;
        chk("mask0_resp", 96'({resp_valid, resp_data}), 96'({1'b1, lanes02}));

        // Starvation: writes t..t+3, read at t+4, response at t+5
        @(negedge clock);
        wr_valid = 1; wr_addr = 9'd20; wr_mask = 4'hF; wr_data = 76'h123;
        rd_valid = 1; rd_addr = 9'd300; #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(negedge clock); #1; end
            chk("starve_wr", 96'({wr_ready, rd_ready}), 96'(2'b10));
        end
        @(negedge clock); #1;
        chk("starve_rd", 96'({wr_ready, rd_ready, sram_wmode, sram_addr}),
            96'({1'b0, 1'b1, 1'b0, 9'd300}));
        @(negedge clock); rd_valid = 0; #1;
        chk("starve_resp", 96'({resp_valid, resp_data, wr_ready}), 96'({1'b1, 76'h0, 1'b1}));
        @(negedge clock); wr_valid = 0; #1;

        // Same-address conflict, write first: read sees new data
        wr_valid = 1; wr_addr = 9'd7; wr_data = 76'hA; #1;
        chk("conf_seed", 96'(wr_ready), 96'(1));
        @(negedge clock); wr_data = 76'hB; rd_valid = 1; rd_addr = 9'd7; #1;
        chk("conf_wr_first", 96'({wr_ready, rd_ready}), 96'(2'b10));
        @(negedge clock); wr_valid = 0; #1;
        chk("conf_rd_next", 96'(rd_ready), 96'(1));
        @(negedge clock); rd_valid = 0; #1;
        chk("conf_new_data", 96'({resp_valid, resp_data}), 96'({1'b1, 76'hB}));

        // Same-address conflict at the starvation limit: read wins, sees old data
        @(negedge clock); wr_valid = 1; wr_addr = 9'd7; wr_data = 76'hA; #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); wr_addr = 9'd8; wr_data = 76'h1; rd_valid = 1; #1;
            chk("lim_wr", 96'({wr_ready, rd_ready}), 96'(2'b10));
        end
        @(negedge clock); wr_addr = 9'd7; wr_data = 76'hB; #1;
        chk("lim_rd_wins", 96'({wr_ready, rd_ready}), 96'(2'b01));
        @(negedge clock); rd_valid = 0; #1;
        chk("lim_old_data", 96'({resp_valid, resp_data, wr_ready}), 96'({1'b1, 76'hA, 1'b1}));
        @(negedge clock); wr_valid = 0; rd_valid = 1; #1;
        @(negedge clock); rd_valid = 0; #1;
        chk("lim_then_new", 96'({resp_valid, resp_data}), 96'({1'b1, 76'hB}));

        // Reset during the read grant cycle: response dropped
        @(negedge clock); rd_valid = 1; rd_addr = 9'd5; watch = 1; #1;
        chk("rst_rd_grant", 96'(rd_ready), 96'(1));
        #2; reset_n = 0; rd_valid = 0; #1;
        chk("rst_run_clear", 96'({resp_valid, init_done, sram_en}), 96'(0));
        @(negedge clock); #1;
        chk("rst_run_noresp", 96'(resp_valid), 96'(0));

        // Restart INIT, then reset again at address 100
        @(negedge clock); reset_n = 1; #1;
        chk("restart0", init_view(), init_exp(0));
        repeat (100) @(negedge clock);
        #1;
        chk("init_at_100", init_view(), init_exp(100));
        reset_n = 0; #1;
        chk("rst_mid_init", 96'({sram_en, init_done}), 96'(0));

        // Requests held through a full INIT: readies stay low, write wins first
        @(negedge clock);
        reset_n = 1; wr_valid = 1; wr_addr = 9'd9; wr_mask = 4'hF; wr_data = 76'h55;
        rd_valid = 1; rd_addr = 9'd9; #1;
        for (int c = 0; c < 512; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            chk("init_req_hold", init_view(), init_exp(c));
        end
        @(negedge clock); #1;
        chk("first_grant_wr", 96'({init_done, wr_ready, rd_ready}), 96'(3'b110));
        chk("no_resp_pulse", 96'(saw_resp), 96'(0));
        @(negedge clock); wr_valid = 0; rd_valid = 0; watch = 0; #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end
endmodule
